// File: rtl/demux1x4_32bit_buf_pkg.sv
// Shared widths, lane select encodings and the select decode used by the 1-to-4 word demux.
package demux1x4_32bit_buf_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        LANE1 = 2'b00,
        LANE2 = 2'b01,
        LANE3 = 2'b10,
        LANE4 = 2'b11
    } lane_e;

    function automatic logic [3:0] lane_decode(input lane_e sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demux1x4_32bit_buf_if.sv
// Producer/consumer bus of the 1-to-4 demux: one input word stream, four buffered output lanes.
interface demux1x4_32bit_buf_if;
    import demux1x4_32bit_buf_pkg::*;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [CNT_W-1:0] count1;
    logic [CNT_W-1:0] count2;
    logic [CNT_W-1:0] count3;
    logic [CNT_W-1:0] count4;

    modport master (
        output in_data, in_valid, s0, s1, out_ready,
        input  in_ready, out1, out2, out3, out4, out_valid,
               count1, count2, count3, count4
    );

    modport slave (
        input  in_data, in_valid, s0, s1, out_ready,
        output in_ready, out1, out2, out3, out4, out_valid,
               count1, count2, count3, count4
    );

endinterface

// File: rtl/demux1x4_32bit_buf_lane.sv
// One output lane: single-entry word buffer with valid/ready and a wrapping accept counter.
module demux_lane
    import demux1x4_32bit_buf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             lane_ready
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_count;

    // A load on a draining lane keeps valid high so the consumer sees no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (load) begin
            r_data  <= ld_data;
            r_valid <= 1'b1;
            r_count <= r_count + 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign count      = r_count;
    assign lane_ready = ~r_valid | out_ready;

endmodule

// File: rtl/demux1x4_32bit_buf.sv
// Registered 1-to-4 demultiplexer: routes each accepted word to the lane chosen by {s1,s0}.
module demux1x4_32bit_buf
    import demux1x4_32bit_buf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    demux1x4_32bit_buf_if.slave  bus
);

    lane_e            w_sel;
    logic             w_accept;
    logic [3:0]       w_load;
    logic             w_lane_ready [4];
    logic             w_valid      [4];
    logic [WIDTH-1:0] w_data       [4];
    logic [CNT_W-1:0] w_count      [4];

    assign w_sel    = lane_e'({bus.s1, bus.s0});
    assign w_accept = bus.in_valid & w_lane_ready[w_sel] & ~reset;
    assign w_load   = lane_decode(w_sel) & {4{w_accept}};

    for (genvar i = 0; i < 4; i++) begin : g_lane
        demux_lane u_lane (
            .clk        (clk),
            .reset      (reset),
            .load       (w_load[i]),
            .ld_data    (bus.in_data),
            .out_ready  (bus.out_ready[i]),
            .data       (w_data[i]),
            .valid      (w_valid[i]),
            .count      (w_count[i]),
            .lane_ready (w_lane_ready[i])
        );
    end

    // in_ready ignores reset so the producer sees a stable, purely state-based ready.
    assign bus.in_ready  = w_lane_ready[w_sel];
    assign bus.out1      = w_data[0];
    assign bus.out2      = w_data[1];
    assign bus.out3      = w_data[2];
    assign bus.out4      = w_data[3];
    assign bus.out_valid = {w_valid[3], w_valid[2], w_valid[1], w_valid[0]};
    assign bus.count1    = w_count[0];
    assign bus.count2    = w_count[1];
    assign bus.count3    = w_count[2];
    assign bus.count4    = w_count[3];

endmodule

// File: tb/tb_demux1x4_32bit_buf.sv
// Bench for the 1-to-4 demux: directed scenarios plus random traffic against a lane-array model.
module tb_demux1x4_32bit_buf;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    demux1x4_32bit_buf_if bus ();

    demux1x4_32bit_buf dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] t_out [4];
    logic [7:0]  t_cnt [4];
    assign t_out[0] = bus.out1;
    assign t_out[1] = bus.out2;
    assign t_out[2] = bus.out3;
    assign t_out[3] = bus.out4;
    assign t_cnt[0] = bus.count1;
    assign t_cnt[1] = bus.count2;
    assign t_cnt[2] = bus.count3;
    assign t_cnt[3] = bus.count4;

    // Reference model: four one-word mailboxes with accept counters.
    logic [31:0] m_data  [4];
    logic        m_valid [4];
    logic [7:0]  m_cnt   [4];

    function automatic logic model_ready();
        int s;
        s = {bus.s1, bus.s0};
        return !m_valid[s] || bus.out_ready[s];
    endfunction

    function automatic logic [3:0] model_valid_vec();
        return {m_valid[3], m_valid[2], m_valid[1], m_valid[0]};
    endfunction

    task automatic drive(input logic v, input int sel, input logic [31:0] d, input logic [3:0] ordy);
        bus.in_valid  = v;
        bus.s1        = sel[1];
        bus.s0        = sel[0];
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        int          s;
        logic        acc;
        logic        r;
        logic [3:0]  ordy;
        logic [31:0] d;
        s    = {bus.s1, bus.s0};
        r    = reset;
        acc  = bus.in_valid && model_ready() && !r;
        ordy = bus.out_ready;
        d    = bus.in_data;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                m_data[i] = '0; m_valid[i] = 1'b0; m_cnt[i] = '0;
            end else if (acc && i == s) begin
                m_data[i] = d; m_valid[i] = 1'b1; m_cnt[i] = m_cnt[i] + 8'd1;
            end else if (m_valid[i] && ordy[i]) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 0, 32'h0, 4'b0000);
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_valid: got %b want 0000", bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (t_out[i] !== 32'h0 || t_cnt[i] !== 8'h0) begin
                errors++; $display("FAIL reset_lane%0d: data %h cnt %0d want 0/0", i + 1, t_out[i], t_cnt[i]);
            end
        end
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, s, 32'h0, 4'b0000);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready sel=%0d: got %b want 1", s, bus.in_ready);
            end
        end
    endtask

    task automatic test_load_all();
        logic [31:0] vals [4];
        vals[0] = 32'hFFFF_FFFF; vals[1] = 32'h0000_0001;
        vals[2] = 32'h0000_0007; vals[3] = 32'hC000_0000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i, vals[i], 4'b0000);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL load_in_ready lane%0d: got %b want 1", i + 1, bus.in_ready);
            end
            tick();
            drive(1'b0, i, 32'h0, 4'b0000);
            checks++;
            if (t_out[i] !== vals[i] || bus.out_valid[i] !== 1'b1) begin
                errors++; $display("FAIL load_lane%0d: data %h valid %b want %h/1", i + 1, t_out[i], bus.out_valid[i], vals[i]);
            end
        end
        checks++;
        if (bus.out_valid !== 4'b1111) begin
            errors++; $display("FAIL load_all_valid: got %b want 1111", bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (t_cnt[i] !== 8'd1) begin
                errors++; $display("FAIL load_count%0d: got %0d want 1", i + 1, t_cnt[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 0, 32'h1234_5678, 4'b0000);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready_full: got %b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out1 !== 32'hFFFF_FFFF || bus.count1 !== 8'd1) begin
            errors++; $display("FAIL bp_lane1_hold: data %h cnt %0d want ffffffff/1", bus.out1, bus.count1);
        end
        drive(1'b1, 1, 32'h1234_5678, 4'b0010);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_in_ready_drain: got %b want 1", bus.in_ready);
        end
        tick();
        drive(1'b0, 1, 32'h0, 4'b0000);
        checks++;
        if (bus.out2 !== 32'h1234_5678 || bus.count2 !== 8'd2 || bus.out_valid !== 4'b1111) begin
            errors++; $display("FAIL bp_lane2_accept: data %h cnt %0d valid %b want 12345678/2/1111",
                               bus.out2, bus.count2, bus.out_valid);
        end
    endtask

    task automatic test_drain_load();
        drive(1'b1, 0, 32'h0000_0002, 4'b0001);
        tick();
        drive(1'b0, 0, 32'h0, 4'b0000);
        checks++;
        if (bus.out_valid[0] !== 1'b1 || bus.out1 !== 32'h0000_0002 || bus.count1 !== 8'd2) begin
            errors++; $display("FAIL drain_load_lane1: valid %b data %h cnt %0d want 1/00000002/2",
                               bus.out_valid[0], bus.out1, bus.count1);
        end
        // Drain everything at once; data must persist after the drain.
        drive(1'b0, 0, 32'h0, 4'b1111);
        tick();
        drive(1'b0, 0, 32'h0, 4'b0000);
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.out4 !== 32'hC000_0000) begin
            errors++; $display("FAIL drain_all: valid %b out4 %h want 0000/c0000000", bus.out_valid, bus.out4);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [7:0]  start;
        start = m_cnt[2];
        d = '0;
        for (int n = 0; n < 256; n++) begin
            d = $urandom;
            drive(1'b1, 2, d, 4'b0100);
            tick();
            checks++;
            if (bus.count3 !== m_cnt[2] || bus.out3 !== d) begin
                errors++; $display("FAIL wrap_step%0d: cnt %0d data %h want %0d/%h", n, bus.count3, bus.out3, m_cnt[2], d);
            end
        end
        drive(1'b0, 2, 32'h0, 4'b0000);
        checks++;
        if (bus.count3 !== start || bus.count1 !== 8'd2) begin
            errors++; $display("FAIL wrap_final: cnt3 %0d cnt1 %0d want %0d/2", bus.count3, bus.count1, start);
        end
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 3, 32'hDEAD_BEEF, 4'b0000);
        tick();
        drive(1'b1, 3, 32'hA5A5_A5A5, 4'b1000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 0, 32'h0, 4'b0000);
        checks++;
        if (bus.out4 !== 32'h0 || bus.out_valid !== 4'b0000 || bus.count4 !== 8'd0) begin
            errors++; $display("FAIL reset_inflight: out4 %h valid %b cnt4 %0d want 0/0000/0",
                               bus.out4, bus.out_valid, bus.count4);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom, 4'($urandom));
            checks++;
            if (bus.in_ready !== model_ready()) begin
                errors++; $display("FAIL rand_in_ready%0d: got %b want %b", n, bus.in_ready, model_ready());
            end
            tick();
            checks++;
            if (bus.out_valid !== model_valid_vec()) begin
                errors++; $display("FAIL rand_valid%0d: got %b want %b", n, bus.out_valid, model_valid_vec());
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (t_out[i] !== m_data[i] || t_cnt[i] !== m_cnt[i]) begin
                    errors++; $display("FAIL rand_lane%0d_%0d: data %h cnt %0d want %h/%0d",
                                       i + 1, n, t_out[i], t_cnt[i], m_data[i], m_cnt[i]);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_data[i] = '0; m_valid[i] = 1'b0; m_cnt[i] = '0;
        end
        drive(1'b0, 0, 32'h0, 4'b0000);
        test_reset();
        test_load_all();
        test_backpressure();
        test_drain_load();
        test_wrap();
        test_reset_inflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
